mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Sub-word load/store unit in front of a 32-bit little-endian memory with a fixed read latency.
// Byte and half stores are done as read-modify-write of the containing word.
module mem_access_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Op,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] mem_raddress,
    output logic [31:0] mem_waddress,
    output logic [31:0] mem_datain,
    output logic        mem_wr,
    input  logic [31:0] mem_dataout
);

    // state | meaning
    // IDLE  | waiting for Start; request fields latched on accept
    // RD    | memory read in flight; r_cnt counts down to the capture cycle
    // WR    | single-cycle memory write (word store or merged sub-word store)
    // DONE  | Done pulse (with Err for rejected requests), back to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_op;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [2:0]  r_cnt;
    logic        r_mem_wr;

    logic        w_misaligned;
    logic [4:0]  w_shift;
    logic [31:0] w_rword;
    logic [31:0] w_load;
    logic [31:0] w_mask;
    logic [31:0] w_merged;

    assign w_misaligned = (Size == 2'b11)
                       || (Size == 2'b10 && Addr[1:0] != 2'b00)
                       || (Size == 2'b01 && Addr[0]);

    assign w_shift  = {r_lane, 3'b000};
    assign w_rword  = mem_dataout >> w_shift;
    assign w_mask   = (r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    assign w_merged = (mem_dataout & ~(w_mask << w_shift)) | ((r_wdata & w_mask) << w_shift);

    always_comb begin
        w_load = w_rword;
        case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_rword[7:0]}  : {{24{w_rword[7]}}, w_rword[7:0]};
            2'b01:   w_load = r_uns ? {16'd0, w_rword[15:0]} : {{16{w_rword[15]}}, w_rword[15:0]};
            default: w_load = w_rword;
        endcase
    end

    // A reset landing in the WR cycle must not let the write reach memory.
    assign mem_wr = r_mem_wr & ~Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_op         <= 1'b0;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= 32'd0;
            r_cnt        <= 3'd0;
            r_mem_wr     <= 1'b0;
            RData        <= 32'd0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Err          <= 1'b0;
            mem_raddress <= 32'd0;
            mem_waddress <= 32'd0;
            mem_datain   <= 32'd0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op    <= Op;
                        r_size  <= Size;
                        r_uns   <= Unsigned;
                        r_lane  <= Addr[1:0];
                        r_wdata <= WData;
                        Busy    <= 1'b1;
                        if (w_misaligned) begin
                            r_state <= S_DONE;
                            Done    <= 1'b1;
                            Err     <= 1'b1;
                        end else if (Op && Size == 2'b10) begin
                            r_state      <= S_WR;
                            mem_waddress <= {Addr[31:2], 2'b00};
                            mem_datain   <= WData;
                            r_mem_wr     <= 1'b1;
                        end else begin
                            r_state      <= S_RD;
                            mem_raddress <= {Addr[31:2], 2'b00};
                            mem_waddress <= {Addr[31:2], 2'b00};
                            r_cnt        <= 3'(READ_LATENCY);
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == 3'd0) begin
                        if (r_op) begin
                            r_state    <= S_WR;
                            mem_datain <= w_merged;
                            r_mem_wr   <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            RData   <= w_load;
                            Done    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_WR: begin
                    r_state  <= S_DONE;
                    r_mem_wr <= 1'b0;
                    Done     <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
